token_embed_stage: RTL and testbench
====================================

Name: token_embed_stage

Overview:
Front-end stage directly upstream of top_transformer_block. Accepts one token id per handshake, looks up its D-element embedding row, adds the positional-embedding row for the current sequence position with saturation, and presents the result on x_out with a one-cycle blk_start pulse. Holds x_out stable and refuses new tokens until the block signals completion (blk_done, wired to the block's out_valid). Both tables are internal register files loaded through write ports.

Parameters:
D, 2, hidden size; elements per vector.
VOCAB, 12, embedding table rows.
SEQ_LEN, 2, positional table rows and position wrap point.
DW, 8, signed element width.
TOK_W, $clog2(VOCAB), token id width.
POS_W, $clog2(SEQ_LEN) (minimum 1), position counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
tok_valid  in  1  token offer.
tok_ready  out  1  high only in S_IDLE.
tok_id  in  TOK_W  token index.
tok_last  in  1  last token of sequence; sampled with tok_id.
emb_we  in  1  embedding table write enable.
emb_waddr  in  $clog2(VOCAB*D)  element address = row*D + dim.
emb_wdata  in  DW  signed element.
pos_we  in  1  positional table write enable.
pos_waddr  in  $clog2(SEQ_LEN*D)  element address = pos*D + dim.
pos_wdata  in  DW  signed element.
blk_start  out  1  one-cycle pulse; x_out valid.
x_out  out  DW x [0:D-1]  signed embedded vector.
blk_done  in  1  downstream completion.
pos_o  out  POS_W  position of the token currently held or issued.
sat_cnt  out  8  saturating count of clamped elements.

Behaviour:
- Reset: tok_ready=1, blk_start=0, x_out all 0, pos_o=0, sat_cnt=0, state S_IDLE. Table contents are not reset. Reset mid-operation abandons the token; no blk_start is issued afterward.
- S_IDLE: tok_ready=1. On tok_valid&tok_ready, latch tok_id and tok_last, then go to S_READ.
- S_READ: register the embedding row tok_id and positional row pos_o. If tok_id>=VOCAB, the embedding row reads as all zeros. Go to S_SUM.
- S_SUM: per element, compute the DW+1-bit sum emb+pos. Clamp it to [-2^(DW-1), 2^(DW-1)-1] and register it into x_out. Add the number of clamped elements to sat_cnt; sat_cnt holds at 255. Go to S_ISSUE.
- S_ISSUE: blk_start=1 for exactly this cycle. Go to S_WAIT.
- S_WAIT: x_out held stable. On blk_done, go to S_IDLE.
  - If latched tok_last=1 or pos_o==SEQ_LEN-1, pos_o becomes 0.
  - Otherwise pos_o increments by 1.
- Latency: blk_start is asserted 3 cycles after the accepting edge. The earliest next accept is the cycle after blk_done is seen.
- blk_done in any state other than S_WAIT is ignored. blk_done coincident with blk_start is also ignored.
- Table writes are accepted in every state.
  - A write in the same cycle as the S_READ read of the same address: the read returns the old value.
  - Write addresses out of range are dropped.
  - emb_we and pos_we may be asserted together.
- x_out changes only in S_SUM and on reset.

Test Plan:
1. Load emb[3]={10,-5} and pos[0]={1,2}; offer tok 3 -> accepted, blk_start 3 cycles later, x_out={11,-3}, pos_o=0, tok_ready=0 until blk_done.
2. Load emb[5]={120,-120} and pos[1]={20,-20}; issue tok 5 at pos 1 -> x_out={127,-128}, sat_cnt increments by 2.
3. Three tokens with tok_last=0 and SEQ_LEN=2 -> pos_o sequence 0,1,0.
4. First token with tok_last=1 -> next token uses pos_o=0. Offer tok_id=13 (>=VOCAB) with pos[0]={4,-4} -> x_out={4,-4}.
5. Pulse blk_done during S_READ -> ignored, blk_start still issued, state remains S_WAIT until a real blk_done. Then assert rst in S_WAIT -> tok_ready=1, x_out={0,0}, pos_o=0, no blk_start.
6. Write emb[3] dim0=50 in the S_READ cycle of tok 3 (old value 10, pos[0]={1,2}) -> x_out[0]=11. The next tok 3 at pos 0 -> x_out[0]=51.

Source files
------------

// File: rtl/token_embed_stage.sv
// token_embed_stage
//
// Front-end stage that feeds top_transformer_block. It accepts one token id
// per handshake and looks up that token's D-element embedding row. It then
// adds the positional row for the current sequence position, saturating each
// element to DW bits. The result goes out on x_out with a one-cycle blk_start
// pulse. x_out stays stable, and no new token is accepted, until the block
// reports completion on blk_done.
//
// Both tables are internal register files. They are loaded element by element
// through independent write ports that work in every state.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   tok_valid/tok_ready token handshake (ready only while idle)
//   tok_id, tok_last    token index and end-of-sequence flag, sampled together
//   emb_we/waddr/wdata  embedding table element write (addr = row*D + dim)
//   pos_we/waddr/wdata  positional table element write (addr = pos*D + dim)
//   blk_start           one-cycle pulse marking x_out valid
//   x_out               signed embedded vector, D elements of DW bits
//   blk_done            downstream completion (block out_valid)
//   pos_o               position of the token currently held or issued
//   sat_cnt             saturating count of clamped elements
module token_embed_stage #(
    parameter int D       = 2,
    parameter int VOCAB   = 12,
    parameter int SEQ_LEN = 2,
    parameter int DW      = 8,
    parameter int TOK_W   = $clog2(VOCAB),
    parameter int POS_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    parameter int EMB_AW  = $clog2(VOCAB * D),
    parameter int POS_AW  = (SEQ_LEN * D > 1) ? $clog2(SEQ_LEN * D) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic [TOK_W-1:0]     tok_id,
    input  logic                 tok_last,
    input  logic                 emb_we,
    input  logic [EMB_AW-1:0]    emb_waddr,
    input  logic signed [DW-1:0] emb_wdata,
    input  logic                 pos_we,
    input  logic [POS_AW-1:0]    pos_waddr,
    input  logic signed [DW-1:0] pos_wdata,
    output logic                 blk_start,
    output logic signed [DW-1:0] x_out [0:D-1],
    input  logic                 blk_done,
    output logic [POS_W-1:0]     pos_o,
    output logic [7:0]           sat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SUM,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    // Latched token
    logic [TOK_W-1:0] tok_q;
    logic             last_q;

    // Table storage
    logic signed [DW-1:0] emb_mem [0:VOCAB*D-1];
    logic signed [DW-1:0] pos_mem [0:SEQ_LEN*D-1];

    // Rows registered in S_READ, summed in S_SUM
    logic signed [DW-1:0] emb_row_q [0:D-1];
    logic signed [DW-1:0] pos_row_q [0:D-1];

    logic [EMB_AW-1:0]    emb_raddr [0:D-1];
    logic [POS_AW-1:0]    pos_raddr [0:D-1];
    logic                 tok_in_range;

    logic signed [DW:0]   sum_w     [0:D-1];
    logic signed [DW-1:0] clamp_w   [0:D-1];
    int                   clamp_total;
    int                   sat_total;
    logic [7:0]           sat_cnt_nxt;

    // ------------------------------------------------------------------
    // Table writes. Out-of-range addresses are dropped. A write that lands
    // in the same cycle as the S_READ lookup is not visible to that lookup:
    // the read samples the old contents at the same edge.
    // ------------------------------------------------------------------
    // NOTE: the tables are plain storage that software always loads before
    // use, so they have no reset; that keeps them out of the reset tree.
    always_ff @(posedge clk) begin
        if (emb_we && (int'(emb_waddr) < VOCAB * D))
            emb_mem[emb_waddr] <= emb_wdata;
        if (pos_we && (int'(pos_waddr) < SEQ_LEN * D))
            pos_mem[pos_waddr] <= pos_wdata;
    end

    // ------------------------------------------------------------------
    // Read addresses for the row lookups
    // ------------------------------------------------------------------
    always_comb begin
        tok_in_range = (int'(tok_q) < VOCAB);
        for (int d = 0; d < D; d++) begin
            emb_raddr[d] = EMB_AW'(int'(tok_q) * D + d);
            pos_raddr[d] = POS_AW'(int'(pos_o) * D + d);
        end
    end

    // ------------------------------------------------------------------
    // Saturating add. The DW+1-bit sum is out of range exactly when its two
    // top bits differ. The top bit then gives the direction of the clamp.
    // ------------------------------------------------------------------
    always_comb begin
        clamp_total = 0;
        for (int d = 0; d < D; d++) begin
            sum_w[d] = {emb_row_q[d][DW-1], emb_row_q[d]} +
                       {pos_row_q[d][DW-1], pos_row_q[d]};
            if (sum_w[d][DW] != sum_w[d][DW-1]) begin
                clamp_w[d]  = sum_w[d][DW] ? {1'b1, {(DW-1){1'b0}}}
                                           : {1'b0, {(DW-1){1'b1}}};
                clamp_total = clamp_total + 1;
            end else begin
                clamp_w[d] = sum_w[d][DW-1:0];
            end
        end
        sat_total   = int'(sat_cnt) + clamp_total;
        sat_cnt_nxt = (sat_total > 255) ? 8'hFF : 8'(sat_total);
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from pre-edge values, independent of
    // statement or process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore outputs. blk_done is only looked at in
    // S_WAIT. So a pulse during the pipeline, or coincident with blk_start,
    // is ignored.
    // ------------------------------------------------------------------
    // NOTE: each output gets a default before the case statement, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        tok_ready = 1'b0;
        blk_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_SUM;
            S_SUM:   state_nxt = S_ISSUE;
            S_ISSUE: begin
                blk_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (blk_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_q   <= '0;
            last_q  <= 1'b0;
            pos_o   <= '0;
            sat_cnt <= '0;
            for (int d = 0; d < D; d++) begin
                emb_row_q[d] <= '0;
                pos_row_q[d] <= '0;
                x_out[d]     <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (tok_valid) begin
                        tok_q  <= tok_id;
                        last_q <= tok_last;
                    end
                end
                S_READ: begin
                    // Token ids beyond the table read as an all-zero row.
                    for (int d = 0; d < D; d++) begin
                        emb_row_q[d] <= tok_in_range ? emb_mem[emb_raddr[d]] : '0;
                        pos_row_q[d] <= pos_mem[pos_raddr[d]];
                    end
                end
                S_SUM: begin
                    x_out   <= clamp_w;
                    sat_cnt <= sat_cnt_nxt;
                end
                S_WAIT: begin
                    // The position advances only when the block finishes
                    // this token. A last token, or the final slot, wraps
                    // the position to 0.
                    if (blk_done) begin
                        if (last_q || (pos_o == POS_W'(SEQ_LEN - 1)))
                            pos_o <= '0;
                        else
                            pos_o <= pos_o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_token_embed_stage.sv
// tb_token_embed_stage
//
// Directed, table-driven bench for token_embed_stage with default parameters
// (D=2, VOCAB=12, SEQ_LEN=2, DW=8). The bench drives inputs and samples
// outputs on the falling clock edge.
module tb_token_embed_stage;

    localparam int D       = 2;
    localparam int VOCAB   = 12;
    localparam int SEQ_LEN = 2;
    localparam int DW      = 8;
    localparam int TOK_W   = 4;
    localparam int POS_W   = 1;
    localparam int EMB_AW  = 5;
    localparam int POS_AW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tok_valid;
    logic                 tok_ready;
    logic [TOK_W-1:0]     tok_id;
    logic                 tok_last;
    logic                 emb_we;
    logic [EMB_AW-1:0]    emb_waddr;
    logic signed [DW-1:0] emb_wdata;
    logic                 pos_we;
    logic [POS_AW-1:0]    pos_waddr;
    logic signed [DW-1:0] pos_wdata;
    logic                 blk_start;
    logic signed [DW-1:0] x_out [0:D-1];
    logic                 blk_done;
    logic [POS_W-1:0]     pos_o;
    logic [7:0]           sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    token_embed_stage #(
        .D(D), .VOCAB(VOCAB), .SEQ_LEN(SEQ_LEN), .DW(DW),
        .TOK_W(TOK_W), .POS_W(POS_W), .EMB_AW(EMB_AW), .POS_AW(POS_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_id    (tok_id),
        .tok_last  (tok_last),
        .emb_we    (emb_we),
        .emb_waddr (emb_waddr),
        .emb_wdata (emb_wdata),
        .pos_we    (pos_we),
        .pos_waddr (pos_waddr),
        .pos_wdata (pos_wdata),
        .blk_start (blk_start),
        .x_out     (x_out),
        .blk_done  (blk_done),
        .pos_o     (pos_o),
        .sat_cnt   (sat_cnt)
    );

    typedef struct {
        int tok;
        bit last;
        int x0;
        int x1;
        int pos;
        int sat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic wr(input bit ew, input int ea, input int ed,
                      input bit pw, input int pa, input int pd);
        @(negedge clk);
        emb_we    = ew;
        emb_waddr = EMB_AW'(ea);
        emb_wdata = DW'(ed);
        pos_we    = pw;
        pos_waddr = POS_AW'(pa);
        pos_wdata = DW'(pd);
        @(negedge clk);
        emb_we = 1'b0;
        pos_we = 1'b0;
    endtask

    task automatic wr_emb(input int row, input int v0, input int v1);
        wr(1'b1, row * D,     v0, 1'b0, 0, 0);
        wr(1'b1, row * D + 1, v1, 1'b0, 0, 0);
    endtask

    task automatic wr_pos(input int row, input int v0, input int v1);
        wr(1'b0, 0, 0, 1'b1, row * D,     v0);
        wr(1'b0, 0, 0, 1'b1, row * D + 1, v1);
    endtask

    // Offer a token. Return at the first falling edge after acceptance,
    // which falls in the S_READ cycle.
    task automatic offer(input int tok, input bit last);
        int n;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_id    = TOK_W'(tok);
        tok_last  = last;
        n = 0;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) check("ready_timeout", 0, 1);
        @(negedge clk);
        tok_valid = 1'b0;
    endtask

    // Count falling edges until blk_start. n0 is the index of the edge
    // the caller is currently on, where 1 is the S_READ edge.
    task automatic wait_start(input int n0, output int n);
        n = n0;
        while (blk_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Call from the blk_start edge: step into S_WAIT, then pulse blk_done.
    task automatic finish_tok();
        @(negedge clk);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
    endtask

    task automatic run_tok(input int tok, input bit last, input bit do_check,
                           input int ex0, input int ex1, input int epos,
                           input int esat, input string tag);
        int n;
        offer(tok, last);
        wait_start(1, n);
        if (do_check) begin
            check({tag, "_latency"}, n, 3);
            check({tag, "_x0"}, int'(x_out[0]), ex0);
            check({tag, "_x1"}, int'(x_out[1]), ex1);
            check({tag, "_pos"}, int'(pos_o), epos);
            check({tag, "_sat"}, int'(sat_cnt), esat);
            check({tag, "_ready_busy"}, int'(tok_ready), 0);
        end else if (blk_start !== 1'b1) begin
            check({tag, "_start_timeout"}, 0, 1);
        end
        @(negedge clk);
        if (do_check) begin
            check({tag, "_start_oneshot"}, int'(blk_start), 0);
            check({tag, "_ready_wait"}, int'(tok_ready), 0);
        end
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        if (do_check) check({tag, "_ready_after_done"}, int'(tok_ready), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;

        // Expected results: x = sat(emb[tok] + pos[p]); rows are
        // emb3={10,-5} emb5={120,-120} emb7={-100,50}; pos0={1,2} pos1={20,-20}
        vecs[0] = '{3,  1'b0,   11,   -3, 0, 0};  // pos 0
        vecs[1] = '{5,  1'b0,  127, -128, 1, 2};  // both clamp
        vecs[2] = '{3,  1'b0,   11,   -3, 0, 2};  // wrapped to 0
        vecs[3] = '{7,  1'b0,  -80,   30, 1, 2};
        vecs[4] = '{5,  1'b1,  121, -118, 0, 2};  // last -> next pos 0
        vecs[5] = '{5,  1'b0,  121, -118, 0, 2};
        vecs[6] = '{5,  1'b0,  127, -128, 1, 4};
        vecs[7] = '{13, 1'b1,    1,    2, 0, 4};  // out of vocab: zero row

        rst       = 1'b1;
        tok_valid = 1'b0;
        tok_id    = '0;
        tok_last  = 1'b0;
        emb_we    = 1'b0;
        emb_waddr = '0;
        emb_wdata = '0;
        pos_we    = 1'b0;
        pos_waddr = '0;
        pos_wdata = '0;
        blk_done  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", int'(tok_ready), 1);
        check("rst_start", int'(blk_start), 0);
        check("rst_x0", int'(x_out[0]), 0);
        check("rst_x1", int'(x_out[1]), 0);
        check("rst_pos", int'(pos_o), 0);
        check("rst_sat", int'(sat_cnt), 0);
        rst = 1'b0;

        // Table load. The last two writes hit both tables in the same cycle.
        wr_emb(3, 10, -5);
        wr_emb(5, 120, -120);
        wr_pos(0, 1, 2);
        wr(1'b1, 14, -100, 1'b1, 2, 20);
        wr(1'b1, 15, 50,   1'b1, 3, -20);

        for (int i = 0; i < 8; i++) begin
            run_tok(vecs[i].tok, vecs[i].last, 1'b1, vecs[i].x0, vecs[i].x1,
                    vecs[i].pos, vecs[i].sat, $sformatf("vec%0d", i));
        end

        // Out-of-vocabulary token with a distinct positional row.
        wr_pos(0, 4, -4);
        run_tok(13, 1'b1, 1'b1, 4, -4, 0, 4, "oov");
        wr_pos(0, 1, 2);

        // A blk_done pulse in S_READ and another alongside blk_start are
        // both ignored.
        offer(3, 1'b0);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        check("early_done_sum_nostart", int'(blk_start), 0);
        @(negedge clk);
        check("early_done_start", int'(blk_start), 1);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        check("coinc_done_oneshot", int'(blk_start), 0);
        repeat (2) @(negedge clk);
        check("early_done_still_wait", int'(tok_ready), 0);
        check("early_done_x0", int'(x_out[0]), 11);
        check("early_done_x1", int'(x_out[1]), -3);
        check("early_done_pos", int'(pos_o), 0);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        check("early_done_released", int'(tok_ready), 1);

        // Reset while holding a result in S_WAIT.
        offer(5, 1'b0);
        wait_start(1, n);
        check("pre_rst_latency", n, 3);
        check("pre_rst_x0", int'(x_out[0]), 127);
        check("pre_rst_x1", int'(x_out[1]), -128);
        check("pre_rst_pos", int'(pos_o), 1);
        check("pre_rst_sat", int'(sat_cnt), 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", int'(tok_ready), 1);
        check("rst_wait_x0", int'(x_out[0]), 0);
        check("rst_wait_x1", int'(x_out[1]), 0);
        check("rst_wait_pos", int'(pos_o), 0);
        check("rst_wait_sat", int'(sat_cnt), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (blk_start) cnt++;
        end
        check("rst_wait_no_start", cnt, 0);

        // Reset in S_READ abandons the token.
        offer(3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (blk_start) cnt++;
        end
        check("rst_read_no_start", cnt, 0);
        check("rst_read_ready", int'(tok_ready), 1);

        // Write emb[3] dim0 in the S_READ cycle: the lookup sees the old value.
        offer(3, 1'b1);
        emb_we    = 1'b1;
        emb_waddr = EMB_AW'(6);
        emb_wdata = DW'(50);
        @(negedge clk);
        emb_we = 1'b0;
        wait_start(2, n);
        check("wr_race_latency", n, 3);
        check("wr_race_x0_old", int'(x_out[0]), 11);
        check("wr_race_x1", int'(x_out[1]), -3);
        finish_tok();
        run_tok(3, 1'b1, 1'b1, 51, -3, 0, 0, "wr_after");

        // Saturation counter: each token clamps two elements (220, -220).
        wr_pos(0, 100, -100);
        repeat (127) run_tok(5, 1'b1, 1'b0, 0, 0, 0, 0, "sat_fill");
        check("sat_254", int'(sat_cnt), 254);
        run_tok(5, 1'b1, 1'b1, 127, -128, 0, 255, "sat_cap");
        run_tok(5, 1'b1, 1'b1, 127, -128, 0, 255, "sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
